// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel-clock divider, h/v position counters,
// sync/active decode, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIX_DIV   = 2,
  parameter int HW        = 11,
  parameter int VW        = 10,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               restart,
  output logic               pix_en,
  output logic [HW-1:0]      hcount,
  output logic [VW-1:0]      vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               active_video,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  // Decode bounds carry one extra bit so a region ending exactly at 2^HW still compares correctly.
  localparam logic [HW:0] H_ACT_END = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_SYN_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_SYN_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_END = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_SYN_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_SYN_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be >= 1");
  end
  if (H_TOTAL > (1 << HW)) begin : g_bad_hw
    $error("vga_timing_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (1 << VW)) begin : g_bad_vw
    $error("vga_timing_gen: V_TOTAL does not fit in VW bits");
  end

  logic          run;
  logic [DW-1:0] div_cnt;
  logic          div_last;
  logic          h_last;
  logic          v_last;
  logic          h_act;
  logic          v_act;
  logic          h_in_sync;
  logic          v_in_sync;

  assign div_last = (div_cnt == DIV_LAST);
  assign h_last   = (hcount == H_LAST);
  assign v_last   = (vcount == V_LAST);
  assign pix_en   = enable & run & div_last;

  // The divider free-runs under enable even before run is set; only pix_en waits for run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else begin
      if (enable) run <= 1'b1;
      if (restart) begin
        div_cnt <= '0;
        hcount  <= '0;
        vcount  <= '0;
      end else if (enable) begin
        div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        if (pix_en) begin
          if (h_last) begin
            hcount <= '0;
            if (v_last) begin
              vcount      <= '0;
              frame_count <= frame_count + 1'b1;
            end else begin
              vcount <= vcount + 1'b1;
            end
          end else begin
            hcount <= hcount + 1'b1;
          end
        end
      end
    end
  end

  assign h_act     = ({1'b0, hcount} < H_ACT_END);
  assign v_act     = ({1'b0, vcount} < V_ACT_END);
  assign h_in_sync = ({1'b0, hcount} >= H_SYN_BEG) && ({1'b0, hcount} < H_SYN_END);
  assign v_in_sync = ({1'b0, vcount} >= V_SYN_BEG) && ({1'b0, vcount} < V_SYN_END);

  assign active_video = run & h_act & v_act;
  assign hsync        = (run & h_in_sync) ? HS_ON : ~HS_ON;
  assign vsync        = (run & v_in_sync) ? VS_ON : ~VS_ON;
  assign line_start   = pix_en & (hcount == '0);
  assign frame_start  = line_start & (vcount == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 line timing, a small mode walked through a
// vector table, pause/restart/async-reset sequences and a 2-bit frame counter wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // default-mode instance
  logic d_rst, d_en, d_rs, d_pe, d_hs, d_vs, d_av, d_ls, d_fs;
  logic [10:0] d_h;
  logic [9:0]  d_v;
  logic [15:0] d_fc;

  // small-mode instance
  logic s_rst, s_en, s_rs, s_pe, s_hs, s_vs, s_av, s_ls, s_fs;
  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic [15:0] s_fc;

  // small-mode instance with 2-bit frame counter
  logic f_rst, f_en, f_rs, f_pe, f_hs, f_vs, f_av, f_ls, f_fs;
  logic [10:0] f_h;
  logic [9:0]  f_v;
  logic [1:0]  f_fc;

  vga_timing_gen u_def (
    .clk(clk), .reset(d_rst), .enable(d_en), .restart(d_rs), .pix_en(d_pe),
    .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs), .active_video(d_av),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .PIX_DIV(1)
  ) u_small (
    .clk(clk), .reset(s_rst), .enable(s_en), .restart(s_rs), .pix_en(s_pe),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs), .active_video(s_av),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .PIX_DIV(1), .FRAME_W(2)
  ) u_fw2 (
    .clk(clk), .reset(f_rst), .enable(f_en), .restart(f_rs), .pix_en(f_pe),
    .hcount(f_h), .vcount(f_v), .hsync(f_hs), .vsync(f_vs), .active_video(f_av),
    .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
  );

  typedef struct {
    int   adv;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic av;
    logic ls;
    logic fs;
    int   fc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   fc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_small();
    vec_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("s_hcount", 32'(s_h), e.h);
    chk("s_vcount", 32'(s_v), e.v);
    chk("s_hsync", 32'(s_hs), 32'(e.hs));
    chk("s_vsync", 32'(s_vs), 32'(e.vs));
    chk("s_active", 32'(s_av), 32'(e.av));
    chk("s_line_start", 32'(s_ls), 32'(e.ls));
    chk("s_frame_start", 32'(s_fs), 32'(e.fs));
    chk("s_frame_count", 32'(s_fc), e.fc);
  endtask

  initial begin
    int n_pe, n_hs_low, n_av, n_ls, n_pe_pair;
    logic prev_pe;

    // small mode, continuous run with PIX_DIV=1: k clocks after the run edge is pixel k
    //          adv  h   v  hs vs av ls fs fc
    tbl.push_back('{ 0,  0, 0, 0, 1, 1, 1, 1, 0});
    tbl.push_back('{ 7,  7, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{ 1,  8, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 2, 10, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{ 2, 12, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{ 1, 13, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 1, 14, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 1,  0, 1, 0, 1, 1, 1, 0, 0});
    tbl.push_back('{37,  7, 3, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{ 8,  0, 4, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{15,  0, 5, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{30,  0, 7, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{14, 14, 7, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{ 1,  0, 0, 0, 1, 1, 1, 1, 1});

    d_rst = 1'b1; d_en = 1'b0; d_rs = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_rs = 1'b0;
    f_rst = 1'b1; f_en = 1'b0; f_rs = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_hcount", 32'(d_h), 0);
    chk("rst_vcount", 32'(d_v), 0);
    chk("rst_active", 32'(d_av), 0);
    chk("rst_hsync", 32'(d_hs), 1);
    chk("rst_vsync", 32'(d_vs), 1);
    chk("rst_pix_en", 32'(d_pe), 0);
    chk("rst_frame_count", 32'(d_fc), 0);
    chk("rst_s_hsync_pos_pol", 32'(s_hs), 0);
    d_rst = 1'b0; s_rst = 1'b0; f_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_pix_en", 32'(d_pe), 0);

    // default mode: one full line of 1600 clk
    d_en = 1'b1;
    repeat (4) @(negedge clk);
    n_pe = 0; n_hs_low = 0; n_av = 0; n_ls = 0; n_pe_pair = 0; prev_pe = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (d_pe) n_pe++;
      if (d_pe && prev_pe) n_pe_pair++;
      if (!d_hs) n_hs_low++;
      if (d_av) n_av++;
      if (d_ls) n_ls++;
      prev_pe = d_pe;
    end
    chk("def_pix_en_count", n_pe, 800);
    chk("def_pix_en_back_to_back", n_pe_pair, 0);
    chk("def_hsync_low_clk", n_hs_low, 192);
    chk("def_active_clk", n_av, 1280);
    chk("def_line_start", n_ls, 1);
    chk("def_vsync_idle", 32'(d_vs), 1);
    d_en = 1'b0;

    // small mode table via scoreboard
    s_en = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      repeat (tbl[i].adv) @(negedge clk);
      pop_small();
    end

    // pause at hcount 5 for 5 clk
    repeat (5) @(negedge clk);
    chk("pause_pre_h", 32'(s_h), 5);
    s_en = 1'b0;
    #1 chk("pause_pix_en_drop", 32'(s_pe), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_hold_h", 32'(s_h), 5);
      chk("pause_pix_en", 32'(s_pe), 0);
    end
    s_en = 1'b1;
    #1 chk("resume_pix_en", 32'(s_pe), 1);
    @(negedge clk);
    chk("resume_h", 32'(s_h), 6);

    // restart at (9,3) of frame 2
    repeat (168) @(negedge clk);
    chk("pre_restart_h", 32'(s_h), 9);
    chk("pre_restart_v", 32'(s_v), 3);
    chk("pre_restart_fc", 32'(s_fc), 2);
    s_rs = 1'b1;
    @(negedge clk);
    chk("restart_h", 32'(s_h), 0);
    chk("restart_v", 32'(s_v), 0);
    chk("restart_fc", 32'(s_fc), 2);
    s_rs = 1'b0;
    #1 chk("restart_frame_start", 32'(s_fs), 1);
    @(negedge clk);
    chk("post_restart_h", 32'(s_h), 1);

    // async reset mid-frame, before the next clk edge
    repeat (3) @(negedge clk);
    chk("pre_areset_h", 32'(s_h), 4);
    #2 s_rst = 1'b1; s_rs = 1'b1;
    #1;
    chk("areset_h", 32'(s_h), 0);
    chk("areset_active", 32'(s_av), 0);
    chk("areset_hsync", 32'(s_hs), 0);
    chk("areset_pix_en", 32'(s_pe), 0);
    chk("areset_fc", 32'(s_fc), 0);
    @(negedge clk);
    chk("areset_hold_pix_en", 32'(s_pe), 0);
    s_rst = 1'b0; s_rs = 1'b0;
    #1 chk("post_reset_run_clear", 32'(s_pe), 0);
    @(negedge clk);
    chk("post_reset_pix_en", 32'(s_pe), 1);
    chk("post_reset_fs", 32'(s_fs), 1);
    @(negedge clk);
    chk("post_reset_h", 32'(s_h), 1);

    // 2-bit frame counter wrap
    f_en = 1'b1;
    @(negedge clk);
    fc_q.push_back(1); fc_q.push_back(2); fc_q.push_back(3);
    fc_q.push_back(0); fc_q.push_back(1);
    for (int i = 0; i < 5; i++) begin
      repeat (120) @(negedge clk);
      chk("fw2_frame_count", 32'(f_fc), fc_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
